// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants (transmitter FSM states, parity modes, default baud divisor).
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD = 2;
  localparam logic [15:0] BAUD_CNT_MAX_DEF = 16'd5208;
endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: bus-side write port and serial output of the configurable UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_BITS-1:0] data_i;
  logic en_i;
  logic full_o;
  logic busy_o;
  logic [$clog2(FIFO_DEPTH):0] level_o;
  logic Tx_o;
  modport master(output data_i, en_i, input full_o, busy_o, level_o, Tx_o);
  modport slave(input data_i, en_i, output full_o, busy_o, level_o, Tx_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with level count; pushes while full are dropped even when popping.
module uart_tx_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [AW:0] level
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic push_ok, pop_ok;
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign dout = mem_q[rd_q];
  always_comb begin
    push_ok = push && !full;
    pop_ok = pop && !empty;
    wr_d = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d = pop_ok ? rd_q + AW'(1) : rd_q;
    level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk) if (push_ok) mem_q[wr_q] <= din;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter (data bits, parity, stop bits, baud divisor).
// UART_TX_FIFO_EN selects a TX FIFO; otherwise a write is taken straight into the shifter.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter logic [15:0] BAUD_CNT_MAX = BAUD_CNT_MAX_DEF,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  uart_tx_cfg_if.slave bus
);
  localparam int BW = $clog2(DATA_BITS + 1);
  uart_tx_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [BW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, payload;
  logic par_q, par_d, stop_q, stop_d, tx_q, tx_d;
  logic avail, tick, last_stop, load;
`ifdef UART_TX_FIFO_EN
  logic empty;
  uart_tx_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(bus.en_i), .pop(load), .din(bus.data_i),
    .dout(payload), .full(bus.full_o), .empty(empty), .level(bus.level_o)
  );
  assign avail = !empty;
`else
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  // Without a FIFO the write strobe itself is "data available"; it only lands when load fires.
  assign avail = bus.en_i;
  assign payload = bus.data_i;
  assign bus.full_o = state_q != IDLE;
  assign bus.level_o = LW'(0);
`endif
  assign tick = cnt_q == BAUD_CNT_MAX;
  assign last_stop = state_q == STOP && tick && stop_q == 1'(STOP_BITS - 1);
  assign load = (state_q == IDLE || last_stop) && avail;
  assign bus.busy_o = state_q != IDLE || bus.level_o != '0;
  assign bus.Tx_o = tx_q;
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || tick) ? '0 : cnt_q + 16'd1;
    idx_d = idx_q;
    sh_d = sh_q;
    par_d = par_q;
    stop_d = stop_q;
    if (load) begin
      state_d = START;
      sh_d = payload;
      par_d = ^payload ^ (PARITY_MODE == PARITY_ODD);
      stop_d = 1'b0;
    end else if (tick) begin
      case (state_q)
        START: begin
          state_d = DATA;
          idx_d = '0;
        end
        DATA: begin
          sh_d = sh_q >> 1;
          idx_d = idx_q + BW'(1);
          if (idx_q == BW'(DATA_BITS - 1))
            state_d = (PARITY_MODE == PARITY_EVEN || PARITY_MODE == PARITY_ODD) ? PARITY : STOP;
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d = last_stop ? IDLE : STOP;
          stop_d = 1'b1;
        end
        default: ;
      endcase
    end
    // Line level follows the next state so Tx_o comes straight from a flop.
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      stop_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      par_q <= par_d;
      stop_q <= stop_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four transmitter configurations checked every cycle against a frame-queue model,
// plus literal frame expectations; honours UART_TX_FIFO_EN.
module tb_uart_tx_cfg;
  localparam int DEPTH = 4;
  localparam int PER = 4;
  localparam int DBS[4] = '{8, 8, 8, 5};
  localparam int PMS[4] = '{0, 1, 2, 0};
  localparam int SBS[4] = '{1, 2, 2, 1};
`ifdef UART_TX_FIFO_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif
  typedef bit bq_t[$];
  logic clk = 0;
  logic rst = 1;
  logic [3:0] en;
  logic [8:0] data [4];
  logic [3:0] tx_w, bz_w, fl_w;
  logic [2:0] lv_w [4];
  logic [8:0] q [4][$];
  bit w [4][$];
  bit rec_tx [4][256];
  bit rec_bz [4][256];
  int ecnt = 0;
  int t0 = 0;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  for (genvar g = 0; g < 4; g++) begin : u
    uart_tx_cfg_if #(.DATA_BITS(DBS[g]), .FIFO_DEPTH(DEPTH)) ifc ();
    assign ifc.data_i = data[g][DBS[g]-1:0];
    assign ifc.en_i = en[g];
    assign tx_w[g] = ifc.Tx_o;
    assign bz_w[g] = ifc.busy_o;
    assign fl_w[g] = ifc.full_o;
    assign lv_w[g] = ifc.level_o;
    uart_tx_cfg #(.DATA_BITS(DBS[g]), .BAUD_CNT_MAX(16'd3), .PARITY_MODE(PMS[g]),
                  .STOP_BITS(SBS[g]), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(ifc));
  end

  // Whole frame as per-cycle line levels: start, LSB-first data, optional parity, stop bits.
  function automatic bq_t frame(input int g, input logic [8:0] d);
    bq_t r;
    bit p = 0;
    bit b;
    for (int k = 0; k < PER; k++) r.push_back(1'b0);
    for (int i = 0; i < DBS[g]; i++) begin
      b = d[i];
      p ^= b;
      for (int k = 0; k < PER; k++) r.push_back(b);
    end
    if (PMS[g] != 0) begin
      b = (PMS[g] == 2) ? !p : p;
      for (int k = 0; k < PER; k++) r.push_back(b);
    end
    for (int k = 0; k < SBS[g] * PER; k++) r.push_back(1'b1);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    int lv, wl;
    bit acc;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        q[i].delete();
        w[i].delete();
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        lv = q[i].size();
        wl = w[i].size();
`ifdef UART_TX_FIFO_EN
        acc = en[i] && lv < DEPTH;
`else
        acc = en[i] && wl <= 1;
`endif
        if (wl > 0) void'(w[i].pop_front());
`ifdef UART_TX_FIFO_EN
        if (w[i].size() == 0 && lv > 0) w[i] = frame(i, q[i].pop_front());
        if (acc) q[i].push_back(data[i]);
`else
        if (acc) w[i] = frame(i, data[i]);
`endif
      end
    end
  end

  task automatic chk(input string nm, input int g, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", nm, g, $time, got, exp);
    end
  endtask

  task automatic tick();
    int ix;
    @(negedge clk);
    ix = ecnt - t0 - 1;
    for (int i = 0; i < 4; i++) begin
      if (ix >= 0 && ix < 256) begin
        rec_tx[i][ix] = tx_w[i];
        rec_bz[i][ix] = bz_w[i];
      end
      chk("tx", i, tx_w[i], w[i].size() > 0 ? w[i][0] : 1);
      chk("busy", i, bz_w[i], int'(w[i].size() > 0 || q[i].size() > 0));
`ifdef UART_TX_FIFO_EN
      chk("full", i, fl_w[i], int'(q[i].size() == DEPTH));
      chk("level", i, lv_w[i], q[i].size());
`else
      chk("full", i, fl_w[i], int'(w[i].size() > 0));
      chk("level", i, lv_w[i], 0);
`endif
    end
  endtask

  task automatic wr(input int i, input logic [8:0] d);
    en[i] = 1'b1;
    data[i] = d;
    tick();
    en[i] = 1'b0;
  endtask

  initial begin
    logic [0:9] a5_seq;
    a5_seq = 10'b0101001011;
    en = '0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx", i, tx_w[i], 1);
      chk("rst_busy", i, bz_w[i], 0);
      chk("rst_full", i, fl_w[i], 0);
      chk("rst_level", i, lv_w[i], 0);
    end
    rst = 0;
    tick();
    // 8N1 0xA5
    t0 = ecnt;
    wr(0, 9'h0A5);
    repeat (50) tick();
`ifdef UART_TX_FIFO_EN
    chk("a5_latency", 0, rec_tx[0][0], 1);
`endif
    for (int k = 0; k < 10; k++) begin
      chk("a5_bit_first", 0, rec_tx[0][L + 4 * k], a5_seq[k]);
      chk("a5_bit_last", 0, rec_tx[0][L + 4 * k + 3], a5_seq[k]);
    end
    chk("a5_busy_end", 0, rec_bz[0][L + 39], 1);
    chk("a5_busy_drop", 0, rec_bz[0][L + 40], 0);
    // 0x07 with even (g1) and odd (g2) parity, two stop bits
    t0 = ecnt;
    en[1] = 1'b1;
    en[2] = 1'b1;
    data[1] = 9'h007;
    data[2] = 9'h007;
    tick();
    en = '0;
    repeat (55) tick();
    chk("p07_d0", 1, rec_tx[1][L + 5], 1);
    chk("p07_d3", 1, rec_tx[1][L + 17], 0);
    chk("even_par", 1, rec_tx[1][L + 37], 1);
    chk("odd_par", 2, rec_tx[2][L + 37], 0);
    chk("stop1", 1, rec_tx[1][L + 41], 1);
    chk("stop2", 1, rec_tx[1][L + 45], 1);
    for (int i = 1; i < 3; i++) begin
      chk("p07_busy_end", i, rec_bz[i][L + 47], 1);
      chk("p07_busy_drop", i, rec_bz[i][L + 48], 0);
    end
    // burst of six consecutive writes
    t0 = ecnt;
    en[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data[0] = 9'(8'h11 * (i + 1));
      tick();
    end
    en[0] = 1'b0;
    chk("burst_full", 0, fl_w[0], 1);
`ifdef UART_TX_FIFO_EN
    chk("burst_level", 0, lv_w[0], 4);
`else
    chk("burst_level", 0, lv_w[0], 0);
`endif
    repeat (200) tick();
`ifdef UART_TX_FIFO_EN
    chk("b2b_stop", 0, rec_tx[0][40], 1);
    chk("b2b_start", 0, rec_tx[0][41], 0);
    chk("burst_busy_end", 0, rec_bz[0][200], 1);
    chk("burst_busy_drop", 0, rec_bz[0][201], 0);
`else
    chk("burst_busy_end", 0, rec_bz[0][39], 1);
    chk("burst_busy_drop", 0, rec_bz[0][40], 0);
`endif
    // 5-bit payload, upper stimulus bits outside the port
    t0 = ecnt;
    wr(3, 9'h1FF);
    repeat (32) tick();
    chk("d5_start", 3, rec_tx[3][L + 1], 0);
    for (int k = 1; k < 7; k++) chk("d5_ones", 3, rec_tx[3][L + 4 * k + 1], 1);
    chk("d5_busy_end", 3, rec_bz[3][L + 27], 1);
    chk("d5_busy_drop", 3, rec_bz[3][L + 28], 0);
    // strobe mid-frame, then strobe held across the final stop tick
    t0 = ecnt;
    wr(0, 9'h055);
    repeat (9) tick();
    wr(0, 9'h0FF);
    repeat (27) tick();
    en[0] = 1'b1;
    data[0] = 9'h00F;
    repeat (3) tick();
    en[0] = 1'b0;
    repeat (45) tick();
`ifndef UART_TX_FIFO_EN
    chk("ign_bit1", 0, rec_tx[0][9], 0);
    chk("ign_bit3", 0, rec_tx[0][17], 0);
    chk("held_stop", 0, rec_tx[0][39], 1);
    chk("held_start", 0, rec_tx[0][40], 0);
    chk("held_d0", 0, rec_tx[0][45], 1);
    chk("held_d4", 0, rec_tx[0][61], 0);
    chk("held_busy_end", 0, rec_bz[0][79], 1);
    chk("held_busy_drop", 0, rec_bz[0][80], 0);
`endif
    rst = 1;
    tick();
    rst = 0;
    tick();
    // asynchronous reset in the middle of data bit 3
    t0 = ecnt;
    wr(0, 9'h0A5);
    repeat (L + 17) tick();
    chk("pre_rst_tx", 0, tx_w[0], 0);
    chk("pre_rst_busy", 0, bz_w[0], 1);
    #2 rst = 1;
    #1;
    chk("async_tx", 0, tx_w[0], 1);
    chk("async_busy", 0, bz_w[0], 0);
    chk("async_level", 0, lv_w[0], 0);
    chk("async_full", 0, fl_w[0], 0);
    tick();
    rst = 0;
    tick();
    t0 = ecnt;
    wr(0, 9'h03C);
    repeat (45) tick();
    chk("post_start", 0, rec_tx[0][L + 1], 0);
    chk("post_d1", 0, rec_tx[0][L + 9], 0);
    chk("post_d2", 0, rec_tx[0][L + 13], 1);
    chk("post_busy_end", 0, rec_bz[0][L + 39], 1);
    chk("post_busy_drop", 0, rec_bz[0][L + 40], 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
